// File: rtl/prim_arbiter_rr_lock.sv
// N:1 round-robin arbiter that holds the winner until it transfers a beat flagged last,
// and pulses err_len_o when a burst grows past MaxBeats beats.
module prim_arbiter_rr_lock #(
    parameter int  N          = 4,
    parameter int  DW         = 32,
    parameter bit  EnDataPort = 1'b1,
    parameter int  MaxBeats   = 16,
    localparam int IdxW       = $clog2(N),
    localparam int CntW       = $clog2(MaxBeats + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         last_i,
    input  logic [N-1:0][DW-1:0] data_i,
    output logic [N-1:0]         gnt_o,
    output logic [IdxW-1:0]      idx_o,
    output logic                 valid_o,
    output logic [DW-1:0]        data_o,
    input  logic                 ready_i,
    output logic                 locked_o,
    output logic                 err_len_o
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_ptr_next;
    logic [IdxW-1:0] r_lock_idx;
    logic [IdxW-1:0] w_lock_idx_next;
    logic [CntW-1:0] r_beat;
    logic [CntW-1:0] w_beat_next;

    logic [IdxW-1:0] w_cand [N];
    logic [N-1:0]    w_cand_req;
    logic [IdxW-1:0] w_winner;
    logic            w_acc;
    logic            w_last_sel;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] x);
        return (x == IdxW'(N - 1)) ? '0 : x + 1'b1;
    endfunction

    // Candidate at offset gi from the pointer, wrapped modulo N (N need not be a power of two).
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IdxW:0] w_sum;
            assign w_sum          = {1'b0, r_ptr} + (IdxW+1)'(gi);
            assign w_cand[gi]     = (w_sum >= (IdxW+1)'(N)) ? IdxW'(w_sum - (IdxW+1)'(N))
                                                            : w_sum[IdxW-1:0];
            assign w_cand_req[gi] = req_i[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        w_winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand_req[i]) begin
                w_winner = w_cand[i];
            end
        end
    end

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        locked_o = 1'b0;
        if (!rst_i) begin
            case (r_state)
                S_IDLE: begin
                    valid_o = |req_i;
                    idx_o   = w_winner;
                end
                S_LOCKED: begin
                    locked_o = 1'b1;
                    idx_o    = r_lock_idx;
                    valid_o  = req_i[r_lock_idx];
                end
                default: ;
            endcase
        end
    end

    assign w_acc      = valid_o & ready_i;
    assign w_last_sel = last_i[idx_o];
    assign err_len_o  = w_acc && (r_state == S_LOCKED) && (r_beat == CntW'(MaxBeats));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt_o[gi] = w_acc && (idx_o == IdxW'(gi));
        end
        if (EnDataPort) begin : g_data
            assign data_o = data_i[idx_o];
        end else begin : g_nodata
            assign data_o = '1;
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_lock_idx_next = r_lock_idx;
        w_beat_next     = r_beat;
        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (w_last_sel) begin
                        w_ptr_next  = next_idx(idx_o);
                        w_beat_next = '0;
                    end else begin
                        w_state_next    = S_LOCKED;
                        w_lock_idx_next = idx_o;
                        w_beat_next     = CntW'(1);
                    end
                end
                S_LOCKED: begin
                    // Saturate so the length error fires only once per burst.
                    if (r_beat != CntW'(MaxBeats + 1)) begin
                        w_beat_next = r_beat + 1'b1;
                    end
                    if (w_last_sel) begin
                        w_state_next = S_IDLE;
                        w_ptr_next   = next_idx(r_lock_idx);
                        w_beat_next  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
            r_beat     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_lock_idx <= w_lock_idx_next;
            r_beat     <= w_beat_next;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk_i) $onehot0(gnt_o));
    a_gnt_acc:    assert property (@(posedge clk_i) (|gnt_o) |-> (valid_o && ready_i));
    a_lock_idx:   assert property (@(posedge clk_i) locked_o |-> (idx_o == r_lock_idx));
    a_idx_range:  assert property (@(posedge clk_i) 32'(idx_o) < N);
    generate
        if (EnDataPort) begin : g_data_chk
            a_data: assert property (@(posedge clk_i) w_acc |-> (data_o == data_i[idx_o]));
        end
    endgenerate

endmodule

// File: tb/tb_prim_arbiter_rr_lock.sv
// Directed bench for prim_arbiter_rr_lock (N=4, MaxBeats=4): vector table plus
// hand-written backpressure and reset-mid-burst sequences.
module tb_prim_arbiter_rr_lock;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
    localparam int IDXW = $clog2(N);

    logic                 clk_i;
    logic                 rst_i;
    logic [N-1:0]         req_i;
    logic [N-1:0]         last_i;
    logic [N-1:0][DW-1:0] data_i;
    logic [N-1:0]         gnt_o;
    logic [IDXW-1:0]      idx_o;
    logic                 valid_o;
    logic [DW-1:0]        data_o;
    logic                 ready_i;
    logic                 locked_o;
    logic                 err_len_o;

    int n_checks = 0;
    int n_errors = 0;

    prim_arbiter_rr_lock #(
        .N          (N),
        .DW         (DW),
        .EnDataPort (1'b1),
        .MaxBeats   (MAXB)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .last_i    (last_i),
        .data_i    (data_i),
        .gnt_o     (gnt_o),
        .idx_o     (idx_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .locked_o  (locked_o),
        .err_len_o (err_len_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] last;
        logic         rdy;
        logic [N-1:0] gnt;
        int           idx;
        logic         valid;
        logic         locked;
        logic         err;
    } vec_t;

    vec_t vecs[$];
    int   seg_a_end;

    function automatic vec_t mk(input logic rst, input logic [N-1:0] req, input logic [N-1:0] last,
                                input logic rdy, input logic [N-1:0] gnt, input int idx,
                                input logic valid, input logic locked, input logic err);
        vec_t v;
        v.rst = rst; v.req = req; v.last = last; v.rdy = rdy;
        v.gnt = gnt; v.idx = idx; v.valid = valid; v.locked = locked; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] req, input logic [N-1:0] last,
                         input logic rdy);
        rst_i   = rst;
        req_i   = req;
        last_i  = last;
        ready_i = rdy;
        #2;
    endtask

    // Compare outputs, print one line, then advance to just after the next rising edge.
    task automatic check_step(input string tag, input logic [N-1:0] gnt, input int idx,
                              input logic valid, input logic locked, input logic err,
                              input logic [DW-1:0] exp_data);
        $display("%s: rst=%b req=%b last=%b rdy=%b -> gnt=%b idx=%0d valid=%b locked=%b err=%b data=%0h",
                 tag, rst_i, req_i, last_i, ready_i, gnt_o, idx_o, valid_o, locked_o, err_len_o, data_o);
        chk({tag, " gnt"},    32'(gnt_o),     32'(gnt));
        chk({tag, " idx"},    32'(idx_o),     32'(idx));
        chk({tag, " valid"},  32'(valid_o),   32'(valid));
        chk({tag, " locked"}, 32'(locked_o),  32'(locked));
        chk({tag, " err"},    32'(err_len_o), 32'(err));
        chk({tag, " data"},   32'(data_o),    32'(exp_data));
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].rdy);
            check_step($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid,
                       vecs[i].locked, vecs[i].err, data_i[vecs[i].idx]);
        end
    endtask

    initial begin
        logic [DW-1:0] p1_data;

        for (int k = 0; k < N; k++) data_i[k] = DW'(8'hA0 + k);
        rst_i = 1'b1; req_i = '0; last_i = '0; ready_i = 1'b1;

        // reset with all ports requesting: nothing granted
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 0));
        // fairness: single-beat requests rotate 0,1,2,3,0,1,2,3
        for (int r = 0; r < 8; r++)
            vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'(1 << (r % 4)), r % 4, 1, 0, 0));
        // move pointer to 2, then a 3-beat burst on port 2 with everyone requesting
        vecs.push_back(mk(0, 4'b0010, 4'b1111, 1, 4'b0010, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 2, 1, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 2, 1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0100, 1, 4'b0100, 2, 1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 1, 0, 0));
        seg_a_end = vecs.size() - 1;
        // (pointer 2 after the backpressure sequence) lock port 0, holder drops request
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0, 0));
        for (int r = 0; r < 4; r++)
            vecs.push_back(mk(0, 4'b1110, 4'b1110, 1, 4'b0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0001, 1, 4'b0001, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 0, 0));
        // 6-beat burst on port 3: error on the 5th accepted beat only
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 4'b1000, 3, 1, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 1, 1, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1000, 1, 4'b1000, 3, 1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 0, 0));

        @(posedge clk_i);
        #1;
        run_range(0, seg_a_end);

        // backpressure while locked on port 1; other ports' data churns
        p1_data = data_i[1];
        drive(0, 4'b0010, 4'b0000, 1);
        check_step("bp_start", 4'b0010, 1, 1, 0, 0, p1_data);
        for (int r = 0; r < 5; r++) begin
            data_i[0] = DW'($urandom); data_i[2] = DW'($urandom); data_i[3] = DW'($urandom);
            drive(0, 4'b1111, 4'b0000, 0);
            check_step($sformatf("bp_wait%0d", r), 4'b0000, 1, 1, 1, 0, p1_data);
        end
        drive(0, 4'b1111, 4'b0010, 1);
        check_step("bp_resume", 4'b0010, 1, 1, 1, 0, p1_data);
        for (int k = 0; k < N; k++) data_i[k] = DW'(8'hA0 + k);

        run_range(seg_a_end + 1, vecs.size() - 1);

        // reset in the middle of a port-2 burst (pointer is 1 here)
        drive(0, 4'b0100, 4'b0000, 1);
        check_step("rst_burst0", 4'b0100, 2, 1, 0, 0, data_i[2]);
        drive(0, 4'b0101, 4'b0000, 1);
        check_step("rst_burst1", 4'b0100, 2, 1, 1, 0, data_i[2]);
        drive(1, 4'b0101, 4'b0000, 1);
        check_step("rst_active", 4'b0000, 0, 0, 0, 0, data_i[0]);
        drive(0, 4'b0101, 4'b0101, 1);
        check_step("rst_after", 4'b0001, 0, 1, 0, 0, data_i[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
